// File: rtl/blocking_mem_16b_pkg.sv
// Shared 16-byte memory message types, request type codes and the
// state encoding for the blocking memory model.
package blocking_mem_16b_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    localparam int LINE_BYTES = 16;

    typedef struct packed {
        logic [2:0]   mtype;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   mtype;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_line_array.sv
// NUM_LINES x 128-bit line storage: byte-enabled synchronous write,
// combinational read. Contents are deliberately not reset.
module mem_line_array #(
    parameter int NUM_LINES = 256,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [15:0]      i_wr_be,
    input  logic [127:0]     i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [127:0]     o_rd_data
);

    logic [127:0] r_mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 16; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/blocking_mem_16b.sv
// Single-outstanding 16-byte line memory: accepts one request, commits or
// captures at acceptance, and answers after a fixed LATENCY.
module blocking_mem_16b
    import blocking_mem_16b_pkg::*;
#(
    parameter  int NUM_LINES = 256,
    parameter  int LATENCY   = 2,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  memreq_msg,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    output mem_resp_16B_t memresp_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy,
    output logic [31:0]   num_reqs,
    output state_t        o_dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where both val and rdy
    // are 1; the sender holds msg stable while val is high and rdy is low.

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    mem_resp_16B_t      r_resp;
    logic [31:0]        r_num_reqs;

    logic               w_accept;
    logic               w_is_wr;
    logic [IDX_W-1:0]   w_idx;
    logic [3:0]         w_off;
    logic [4:0]         w_n;
    logic [15:0]        w_n_mask;
    logic [15:0]        w_wr_be;
    logic [127:0]       w_wr_data;
    logic [127:0]       w_line;
    logic [127:0]       w_rd_shift;
    logic [127:0]       w_rd_data;
    mem_resp_16B_t      w_resp;
    logic               w_unused_addr;

    assign memreq_rdy  = (r_state == ST_IDLE) && reset;
    assign memresp_val = (r_state == ST_RESP);
    assign memresp_msg = r_resp;
    assign num_reqs    = r_num_reqs;
    assign o_dbg_state = r_state;

    assign w_accept = memreq_val && memreq_rdy;
    assign w_is_wr  = (memreq_msg.mtype == MEM_TYPE_WRITE) ||
                      (memreq_msg.mtype == MEM_TYPE_INIT);

    // Upper address bits alias onto the array; only the index field matters.
    assign w_idx         = memreq_msg.addr[4 +: IDX_W];
    assign w_off         = memreq_msg.addr[3:0];
    assign w_unused_addr = ^memreq_msg.addr;

    assign w_n      = (memreq_msg.len == 4'd0) ? 5'd16 : {1'b0, memreq_msg.len};
    assign w_n_mask = 16'hFFFF >> (5'd16 - w_n);
    // Shifting left past byte 15 drops bytes instead of wrapping into the next line.
    assign w_wr_be   = w_n_mask << w_off;
    assign w_wr_data = memreq_msg.data << {w_off, 3'b000};

    mem_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_accept && w_is_wr),
        .i_wr_idx  (w_idx),
        .i_wr_be   (w_wr_be),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_line)
    );

    always_comb begin
        w_rd_data  = '0;
        w_rd_shift = w_line >> {w_off, 3'b000};
        for (int b = 0; b < 16; b++) begin
            w_rd_data[b*8 +: 8] = w_rd_shift[b*8 +: 8] & {8{w_n_mask[b]}};
        end
    end

    always_comb begin
        w_resp        = '0;
        w_resp.mtype  = memreq_msg.mtype;
        w_resp.opaque = memreq_msg.opaque;
        w_resp.len    = memreq_msg.len;
        if (memreq_msg.mtype == MEM_TYPE_READ) begin
            w_resp.data = w_rd_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(1)) w_state_next = ST_RESP;
            ST_RESP: if (memresp_rdy) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_resp     <= '0;
            r_num_reqs <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt  <= CNT_W'(LATENCY - 1);
                r_resp <= w_resp;
                if (r_num_reqs != 32'hFFFF_FFFF) begin
                    r_num_reqs <= r_num_reqs + 32'd1;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_blocking_mem_16b.sv
// Directed bench for blocking_mem_16b with a byte-level memory model and a
// per-cycle response scoreboard.
`timescale 1ns/1ps
module tb_blocking_mem_16b;
    import blocking_mem_16b_pkg::*;

    localparam int NUM_LINES = 256;
    localparam int LATENCY   = 2;
    localparam int RESP_W    = $bits(mem_resp_16B_t);

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    mem_resp_16B_t memresp_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    logic [31:0]   num_reqs;
    state_t        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        mdl [NUM_LINES*16];
    logic [RESP_W-1:0] exp_q [$];
    logic [31:0]       exp_num;
    logic              chk_en = 1'b0;

    always #5 clk = ~clk;

    blocking_mem_16b #(
        .NUM_LINES (NUM_LINES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .num_reqs    (num_reqs),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                            input logic [31:0] a, input logic [3:0] l,
                                            input logic [127:0] d);
        mem_req_16B_t q;
        q.mtype  = t;
        q.opaque = op;
        q.addr   = a;
        q.len    = l;
        q.data   = d;
        return q;
    endfunction

    // Byte-addressed view of memory: line = addr/16 mod NUM_LINES, bytes past 15 dropped.
    task automatic model_accept(input mem_req_16B_t q, output mem_resp_16B_t r);
        int line, off, n;
        line = int'(q.addr >> 4) % NUM_LINES;
        off  = int'(q.addr[3:0]);
        n    = (q.len == 4'd0) ? 16 : int'(q.len);
        r        = '0;
        r.mtype  = q.mtype;
        r.opaque = q.opaque;
        r.len    = q.len;
        if (q.mtype == MEM_TYPE_WRITE || q.mtype == MEM_TYPE_INIT) begin
            for (int i = 0; i < n; i++)
                if (off + i < 16) mdl[line*16 + off + i] = q.data[i*8 +: 8];
        end else if (q.mtype == MEM_TYPE_READ) begin
            for (int i = 0; i < 16; i++)
                if (i < n && off + i < 16) r.data[i*8 +: 8] = mdl[line*16 + off + i];
        end
        exp_num++;
    endtask

    // Scoreboard: checks every cycle, mid-low-phase, after the driver's negedge updates.
    logic          prev_val = 1'b0;
    logic          prev_rdy = 1'b0;
    mem_resp_16B_t prev_msg;

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (memresp_val) begin
                chk("resp_blocks_req", 160'(memreq_rdy), 160'(0));
                if (prev_val && !prev_rdy)
                    chk("resp_msg_stable", 160'(memresp_msg), 160'(prev_msg));
                if (memresp_rdy) begin
                    if (exp_q.size() == 0) chk("unexpected_resp", 160'(memresp_val), 160'(0));
                    else                   chk("resp_msg", 160'(memresp_msg), 160'(exp_q.pop_front()));
                end
            end
            chk("num_reqs", 160'(num_reqs), 160'(exp_num));
            prev_val = memresp_val;
            prev_rdy = memresp_rdy;
            prev_msg = memresp_msg;
        end
    end

    // Called at a negedge. Issues one request, checks latency, optionally
    // back-pressures the response for 'stall' cycles, returns the response.
    task automatic do_req(input mem_req_16B_t q, input int stall, output mem_resp_16B_t got);
        mem_resp_16B_t r;
        mem_resp_16B_t held;
        int waited;
        int k;
        waited = 0;
        while (!memreq_rdy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_rdy_before_issue", 160'(memreq_rdy), 160'(1));
        memresp_rdy = (stall == 0);
        memreq_msg  = q;
        memreq_val  = 1'b1;
        @(posedge clk);
        model_accept(q, r);
        exp_q.push_back(r);
        @(negedge clk);
        memreq_val = 1'b0;
        k = 1;
        while (!memresp_val && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("resp_latency", 160'(k), 160'(LATENCY));
        got  = memresp_msg;
        held = memresp_msg;
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                chk("bp_val_held", 160'(memresp_val), 160'(1));
                chk("bp_msg_held", 160'(memresp_msg), 160'(held));
                chk("bp_req_rdy_low", 160'(memreq_rdy), 160'(0));
            end
            memresp_rdy = 1'b1;
        end
        @(negedge clk);
        chk("idle_after_resp_rdy", 160'(memreq_rdy), 160'(1));
        chk("idle_after_resp_val", 160'(memresp_val), 160'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_resp_16B_t got;
        logic [127:0]  d0;
        logic [127:0]  d1;
        logic [127:0]  d2;
        d0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        d1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        d2 = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
        for (int i = 0; i < NUM_LINES*16; i++) mdl[i] = 8'h00;

        reset       = 1'b0;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b1;
        exp_num     = '0;

        // Reset held for two rising edges
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_resp_val", 160'(memresp_val), 160'(0));
            chk("rst_num_reqs", 160'(num_reqs), 160'(0));
            chk("rst_req_rdy", 160'(memreq_rdy), 160'(0));
            chk("rst_state", 160'(dbg_state), 160'(ST_IDLE));
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy", 160'(memreq_rdy), 160'(1));
        chk("post_rst_resp_val", 160'(memresp_val), 160'(0));
        chk_en = 1'b1;

        // Init full line, then read it back
        do_req(mk_req(MEM_TYPE_INIT, 8'h05, 32'h100, 4'd0, d0), 0, got);
        chk("init_resp_type", 160'(got.mtype), 160'(2));
        chk("init_resp_opaque", 160'(got.opaque), 160'(8'h05));
        chk("init_resp_data", 160'(got.data), 160'(0));
        do_req(mk_req(MEM_TYPE_READ, 8'h06, 32'h100, 4'd0, '0), 0, got);
        chk("read_full_data", 160'(got.data), 160'(d0));

        // Partial write and reads
        do_req(mk_req(MEM_TYPE_WRITE, 8'h07, 32'h104, 4'd4, 128'hDEADBEEF), 0, got);
        chk("write_resp_type", 160'(got.mtype), 160'(1));
        do_req(mk_req(MEM_TYPE_READ, 8'h08, 32'h104, 4'd4, '0), 0, got);
        chk("read_partial_data", 160'(got.data), 160'(128'hDEADBEEF));
        chk("read_partial_len", 160'(got.len), 160'(4));

        // Full-line read under five cycles of response back-pressure
        do_req(mk_req(MEM_TYPE_READ, 8'h09, 32'h100, 4'd0, '0), 5, got);
        chk("read_merged_data", 160'(got.data), 160'(128'h00112233_44556677_DEADBEEF_CCDDEEFF));

        // Address wrap: 0x1000 aliases line 0
        do_req(mk_req(MEM_TYPE_WRITE, 8'h0A, 32'h1000, 4'd0, d1), 0, got);
        do_req(mk_req(MEM_TYPE_INIT, 8'h0B, 32'h10, 4'd0, d2), 0, got);
        do_req(mk_req(MEM_TYPE_READ, 8'h0C, 32'h0, 4'd0, '0), 0, got);
        chk("wrap_read_data", 160'(got.data), 160'(d1));

        // Write overflowing the line end touches only bytes 14-15
        do_req(mk_req(MEM_TYPE_WRITE, 8'h0D, 32'h0E, 4'd4, 128'h11223344), 0, got);
        do_req(mk_req(MEM_TYPE_READ, 8'h0E, 32'h0, 4'd0, '0), 0, got);
        chk("overflow_line0", 160'(got.data), 160'(128'h33440D0C_0B0A0908_07060504_03020100));
        do_req(mk_req(MEM_TYPE_READ, 8'h0F, 32'h10, 4'd0, '0), 0, got);
        chk("overflow_line1", 160'(got.data), 160'(d2));

        // Unknown type: echoed, no data, no array change
        do_req(mk_req(3'd3, 8'h3C, 32'h100, 4'd7, 128'hFFFF_FFFF), 0, got);
        chk("other_type", 160'(got.mtype), 160'(3));
        chk("other_len", 160'(got.len), 160'(7));
        chk("other_data", 160'(got.data), 160'(0));
        do_req(mk_req(MEM_TYPE_READ, 8'h10, 32'h100, 4'd0, '0), 0, got);
        chk("other_no_write", 160'(got.data), 160'(128'h00112233_44556677_DEADBEEF_CCDDEEFF));

        // Reset while a read is in flight: it must be dropped
        memreq_msg = mk_req(MEM_TYPE_READ, 8'h77, 32'h100, 4'd0, '0);
        memreq_val = 1'b1;
        @(posedge clk);
        exp_num++;
        @(negedge clk);
        memreq_val = 1'b0;
        chk("midop_busy", 160'(dbg_state), 160'(ST_BUSY));
        chk_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        exp_num = '0;
        repeat (2) begin
            @(negedge clk);
            chk("midop_rst_req_rdy", 160'(memreq_rdy), 160'(0));
            chk("midop_rst_resp_val", 160'(memresp_val), 160'(0));
            chk("midop_rst_num_reqs", 160'(num_reqs), 160'(0));
        end
        reset    = 1'b1;
        prev_val = 1'b0;
        chk_en   = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midop_no_resp", 160'(memresp_val), 160'(0));
        end
        do_req(mk_req(MEM_TYPE_READ, 8'h11, 32'h104, 4'd4, '0), 0, got);
        chk("post_rst_read", 160'(got.data), 160'(128'hDEADBEEF));
        chk("post_rst_num_reqs", 160'(num_reqs), 160'(1));

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 160'(exp_q.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
